// File: rtl/ram_stream_reader_if.sv
// Bundle of the reader's control, RAM-port and output-stream signals.
// master: the reader itself. slave: the surrounding system (requester, RAM, sink).
interface ram_stream_reader_if #(
  parameter int unsigned DepthBits = 10,
  parameter int unsigned WidthBits = 36
);

  // Transfer control
  logic                 start;
  logic [DepthBits-1:0] start_addr;
  logic [DepthBits:0]   length;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 aborted;

  // RAM read port
  logic                 ram_en;
  logic                 ram_we;
  logic [DepthBits-1:0] ram_addr;
  logic [WidthBits-1:0] ram_do;

  // Output stream
  logic                 m_valid;
  logic                 m_ready;
  logic [WidthBits-1:0] m_data;
  logic                 m_last;

  modport master (
    input  start, start_addr, length, abort, ram_do, m_ready,
    output busy, done, aborted, ram_en, ram_we, ram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, start_addr, length, abort, ram_do, m_ready,
    input  busy, done, aborted, ram_en, ram_we, ram_addr, m_valid, m_data, m_last
  );

endinterface

// File: rtl/ram_stream_reader.sv
// Sequential reader for a fixed-latency RAM port, presenting the words as a
// valid/ready stream. A tag pipe tracks in-flight reads and a small skid FIFO
// absorbs the read latency; reads are issued only while FIFO space is reserved.
module ram_stream_reader #(
  parameter int unsigned DepthBits = 10,
  parameter int unsigned WidthBits = 36,
  parameter int unsigned RdLatency = 2,
  parameter int unsigned FifoDepth = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  ram_stream_reader_if.master bus
);

  localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW    = $clog2(FifoDepth + 1);
  localparam int unsigned OccW    = CntW + 1;
  localparam int unsigned FlightW = $clog2(RdLatency + 1);

  localparam logic [OccW-1:0]   FifoDepthOcc = OccW'(FifoDepth);
  localparam logic [PtrW-1:0]   PtrLast      = PtrW'(FifoDepth - 1);
  localparam logic [DepthBits:0] RemOne      = (DepthBits + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_e;

  state_e                 state_q, state_d;
  logic [DepthBits-1:0]   addr_q, addr_d;
  logic [DepthBits:0]     rem_q, rem_d;
  logic                   discard_q, discard_d;
  logic                   busy_q, done_q, aborted_q, ram_en_q;

  logic [RdLatency-1:0]   tag_v_q, tag_v_d;
  logic [RdLatency-1:0]   tag_l_q, tag_l_d;

  logic [WidthBits:0]     fifo_q [FifoDepth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic                   flush, issue, issue_last, exit_v, push, pop;
  logic [FlightW-1:0]     inflight;
  logic [OccW-1:0]        occ;

  function automatic logic [FlightW-1:0] popcount(input logic [RdLatency-1:0] v);
    logic [FlightW-1:0] n;
    n = '0;
    for (int i = 0; i < RdLatency; i++) begin
      n = n + FlightW'(v[i]);
    end
    return n;
  endfunction

  // Issue credit, tag pipe, FIFO push/pop and pointer next-state.
  always_comb begin
    flush      = bus.abort && (state_q == StRead || state_q == StDrain);
    inflight   = popcount(tag_v_q);
    occ        = OccW'(cnt_q) + OccW'(inflight);
    // Credit counts in-flight reads so the FIFO can never overflow.
    issue      = (state_q == StRead) && !bus.abort && (occ < FifoDepthOcc);
    issue_last = issue && (rem_q == RemOne);

    // The tag pipe moves only when the RAM port is enabled, exactly like the data.
    tag_v_d = tag_v_q;
    tag_l_d = tag_l_q;
    if (ram_en_q) begin
      tag_v_d[0] = issue;
      tag_l_d[0] = issue_last;
      for (int i = 1; i < RdLatency; i++) begin
        tag_v_d[i] = tag_v_q[i-1];
        tag_l_d[i] = tag_l_q[i-1];
      end
    end

    exit_v = ram_en_q && tag_v_q[RdLatency-1];
    // After an abort, words still in flight are retired without being stored.
    push   = exit_v && !discard_q && !flush;
    pop    = (cnt_q != '0) && bus.m_ready && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Transfer FSM next-state, address and remaining-word counter.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    discard_d = discard_q;
    case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (bus.start) begin
          addr_d  = bus.start_addr;
          rem_d   = bus.length;
          state_d = (bus.length == '0) ? StFinish : StRead;
        end
      end
      StRead: begin
        if (flush) begin
          state_d   = StDrain;
          discard_d = 1'b1;
        end else if (issue_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (flush) discard_d = 1'b1;
        // Look ahead so FINISH follows the cycle that empties pipe and FIFO.
        if (tag_v_d == '0 && cnt_d == '0) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (issue) begin
      addr_d = addr_q + DepthBits'(1);
      rem_d  = rem_q - RemOne;
    end
  end

  // FSM state and registered status/RAM-enable outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      discard_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ram_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      discard_q <= discard_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_q == StFinish);
      aborted_q <= (state_q == StFinish) && discard_q;
      ram_en_q  <= (state_d == StRead) || (state_d == StDrain);
    end
  end

  // In-flight tag pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_q <= '0;
      tag_l_q <= '0;
    end else begin
      tag_v_q <= tag_v_d;
      tag_l_q <= tag_l_d;
    end
  end

  // Skid FIFO storage and pointers; storage is cleared so m_data reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= {tag_l_q[RdLatency-1], bus.ram_do};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = addr_q;
  assign bus.m_valid  = (cnt_q != '0);
  assign bus.m_data   = fifo_q[rd_ptr_q][WidthBits-1:0];
  assign bus.m_last   = fifo_q[rd_ptr_q][WidthBits];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 2-cycle-latency RAM
// preloaded so mem[i] = i. Outputs are sampled 1ns after the rising edge, and the
// inputs for the following edge are set at that same point.
module tb_ram_stream_reader;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.DepthBits(10), .WidthBits(36)) bus ();

  ram_stream_reader #(
    .DepthBits(10),
    .WidthBits(36),
    .RdLatency(2),
    .FifoDepth(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // RAM model: address register stage, then output register, both gated by ram_en.
  logic [35:0] mem [1024];
  logic [35:0] r1;
  initial for (int i = 0; i < 1024; i++) mem[i] = 36'(i);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1         <= '0;
      bus.ram_do <= '0;
    end else if (bus.ram_en) begin
      r1         <= mem[bus.ram_addr];
      bus.ram_do <= r1;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [35:0] got_data [$];
  logic        got_last [$];
  logic [9:0]  addr_log [$];
  int          first_valid_k, done_k, last_pop_k, abort_k, en_rises, busy_cycles;
  logic        valid_after_abort, done_aborted, done_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer; sample k is taken just after edge k, edge 0 being the start edge.
  // ready_mode 0: m_ready held high; 1: m_ready pattern 1,0,0,1,0 repeated.
  task automatic run_xfer(input logic [9:0] sa, input logic [10:0] len, input int ready_mode,
                          input int abort_after, input int budget);
    int pops = 0;
    bit abort_pending = 0;
    bit prev_en = 0;
    got_data.delete();
    got_last.delete();
    addr_log.delete();
    first_valid_k = -1; done_k = -1; last_pop_k = -1; abort_k = -1;
    en_rises = 0; busy_cycles = 0;
    valid_after_abort = 1'b0; done_aborted = 1'b0; done_busy = 1'b0;
    bus.start = 1'b1; bus.start_addr = sa; bus.length = len; bus.abort = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 0; k <= budget; k++) begin
      tick();
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.ram_en && !prev_en) en_rises++;
      prev_en = bus.ram_en;
      if (bus.ram_en && (addr_log.size() == 0 || addr_log[$] != bus.ram_addr))
        addr_log.push_back(bus.ram_addr);
      if (bus.m_valid && first_valid_k < 0) first_valid_k = k;
      if (abort_k >= 0 && k == abort_k + 1) valid_after_abort = bus.m_valid;
      if (bus.done) begin
        done_k = k; done_aborted = bus.aborted; done_busy = bus.busy;
        bus.abort = 1'b0; bus.m_ready = 1'b1;
        break;
      end
      if (abort_pending) begin
        bus.abort = 1'b1; bus.m_ready = 1'b0; abort_k = k; abort_pending = 0;
      end else begin
        bus.abort = 1'b0;
        bus.m_ready = (ready_mode == 0) ? 1'b1 : ((k % 5 == 0) || (k % 5 == 3));
      end
      if (bus.m_valid && bus.m_ready && !bus.abort) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        last_pop_k = k;
        pops++;
        if (abort_after > 0 && pops == abort_after) abort_pending = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.abort = 1'b0; bus.m_ready = 1'b0;
    tick(); tick();
    total++;
    if ({bus.busy, bus.done, bus.aborted, bus.ram_en, bus.m_valid, bus.m_last} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {bus.busy, bus.done, bus.aborted, bus.ram_en, bus.m_valid, bus.m_last});
    end
    reset_n = 1'b1;
    tick();
    total++;
    if ({bus.ram_we, bus.ram_addr, bus.m_data} !== 47'h0) begin
      bad++;
      $display("FAIL reset_bus got we=%b addr=%h data=%h want all 0",
               bus.ram_we, bus.ram_addr, bus.m_data);
    end
  endtask

  task automatic test_basic();
    logic [7:0] lastmask;
    run_xfer(10'h010, 11'd8, 0, 0, 60);
    total++;
    if (first_valid_k !== 3) begin
      bad++; $display("FAIL basic_first_valid got=%0d want=3", first_valid_k);
    end
    total++;
    if (got_data.size() !== 8) begin
      bad++; $display("FAIL basic_count got=%0d want=8", got_data.size());
    end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 36'(16 + i)) begin
        bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, got_data[i], 36'(16 + i));
      end
    end
    lastmask = '0;
    for (int i = 0; i < 8 && i < got_last.size(); i++) lastmask[i] = got_last[i];
    total++;
    if (lastmask !== 8'h80) begin
      bad++; $display("FAIL basic_last got=%b want=10000000", lastmask);
    end
    total++;
    if (last_pop_k !== 10 || done_k !== 12) begin
      bad++; $display("FAIL basic_done_timing got pop=%0d done=%0d want pop=10 done=12",
                      last_pop_k, done_k);
    end
    total++;
    if ({done_aborted, done_busy} !== 2'b00) begin
      bad++; $display("FAIL basic_done_flags got aborted=%b busy=%b want 0 0",
                      done_aborted, done_busy);
    end
  endtask

  task automatic test_wrap();
    logic [39:0] addrs, want_a;
    logic [143:0] words, want_w;
    run_xfer(10'h3FE, 11'd4, 0, 0, 40);
    addrs = 'x; words = 'x;
    if (addr_log.size() >= 4) addrs = {addr_log[0], addr_log[1], addr_log[2], addr_log[3]};
    if (got_data.size() >= 4) words = {got_data[0], got_data[1], got_data[2], got_data[3]};
    want_a = {10'h3FE, 10'h3FF, 10'h000, 10'h001};
    want_w = {36'h3FE, 36'h3FF, 36'h000, 36'h001};
    total++;
    if (addrs !== want_a) begin
      bad++; $display("FAIL wrap_addr got=%h want=%h", addrs, want_a);
    end
    total++;
    if (words !== want_w || got_data.size() !== 4) begin
      bad++; $display("FAIL wrap_data got=%h n=%0d want=%h n=4", words, got_data.size(), want_w);
    end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    run_xfer(10'h080, 11'd16, 1, 0, 200);
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] !== 36'(128 + i) || got_last[i] !== (i == 15)) errs++;
    total++;
    if (got_data.size() !== 16 || errs !== 0) begin
      bad++; $display("FAIL bp_words got n=%0d errs=%0d want n=16 errs=0", got_data.size(), errs);
    end
    total++;
    if (en_rises !== 1) begin
      bad++; $display("FAIL bp_ram_en_rises got=%0d want=1", en_rises);
    end
    total++;
    if (done_k < 0 || done_aborted !== 1'b0) begin
      bad++; $display("FAIL bp_done got k=%0d aborted=%b want done with aborted=0",
                      done_k, done_aborted);
    end
  endtask

  task automatic test_zero_length();
    run_xfer(10'h123, 11'd0, 0, 0, 10);
    total++;
    if (done_k !== 1 || busy_cycles !== 1) begin
      bad++; $display("FAIL zero_timing got done=%0d busy=%0d want done=1 busy=1",
                      done_k, busy_cycles);
    end
    total++;
    if (en_rises !== 0 || first_valid_k !== -1) begin
      bad++; $display("FAIL zero_quiet got en_rises=%0d first_valid=%0d want 0 and -1",
                      en_rises, first_valid_k);
    end
  endtask

  task automatic test_abort();
    int errs = 0;
    int lat;
    run_xfer(10'h200, 11'd32, 0, 5, 100);
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] !== 36'(512 + i)) errs++;
    total++;
    if (got_data.size() !== 5 || errs !== 0) begin
      bad++; $display("FAIL abort_words got n=%0d errs=%0d want n=5 errs=0", got_data.size(), errs);
    end
    total++;
    if (abort_k < 0 || valid_after_abort !== 1'b0) begin
      bad++; $display("FAIL abort_valid_drop got abort_k=%0d m_valid=%b want m_valid=0",
                      abort_k, valid_after_abort);
    end
    lat = done_k - (abort_k + 1);
    total++;
    if (done_k < 0 || lat < 1 || lat > 4 || done_aborted !== 1'b1) begin
      bad++; $display("FAIL abort_done got lat=%0d aborted=%b want lat 1..4 aborted=1",
                      lat, done_aborted);
    end
    run_xfer(10'h100, 11'd4, 0, 0, 40);
    errs = 0;
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] !== 36'(256 + i)) errs++;
    total++;
    if (got_data.size() !== 4 || errs !== 0 || done_aborted !== 1'b0) begin
      bad++; $display("FAIL abort_restart got n=%0d errs=%0d aborted=%b want n=4 errs=0 aborted=0",
                      got_data.size(), errs, done_aborted);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int errs = 0;
    bus.start = 1'b1; bus.start_addr = 10'h020; bus.length = 11'd16; bus.m_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.ram_en, bus.m_valid, bus.m_last} !== 5'b0 ||
        bus.ram_addr !== 10'h0 || bus.m_data !== 36'h0) begin
      bad++; $display("FAIL reset_mid_async got flags=%b addr=%h data=%h want all 0",
                      {bus.busy, bus.done, bus.ram_en, bus.m_valid, bus.m_last},
                      bus.ram_addr, bus.m_data);
    end
    tick(); tick();
    reset_n = 1'b1;
    repeat (6) begin
      tick();
      if (bus.done || bus.m_valid || bus.busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL reset_mid_quiet got active_cycles=%0d want=0", dones);
    end
    run_xfer(10'h040, 11'd3, 0, 0, 40);
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] !== 36'(64 + i)) errs++;
    total++;
    if (got_data.size() !== 3 || errs !== 0 || done_k < 0) begin
      bad++; $display("FAIL reset_mid_restart got n=%0d errs=%0d done_k=%0d want n=3 errs=0",
                      got_data.size(), errs, done_k);
    end
  endtask

  task automatic test_full_length();
    int errs = 0;
    run_xfer(10'h005, 11'h400, 0, 0, 1200);
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] !== 36'((5 + i) % 1024) || got_last[i] !== (i == 1023)) errs++;
    total++;
    if (got_data.size() !== 1024 || errs !== 0) begin
      bad++; $display("FAIL full_words got n=%0d errs=%0d want n=1024 errs=0",
                      got_data.size(), errs);
    end
    total++;
    if (got_data.size() == 0 || got_data[$] !== 36'h004 || done_k < 0) begin
      bad++; $display("FAIL full_end got last=%h done_k=%0d want last=004 and done",
                      (got_data.size() == 0) ? 36'hx : got_data[$], done_k);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_abort();
    test_reset_mid();
    test_full_length();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
